// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: decoder/config inputs and program-counter/status outputs of the fetch sequencer
interface fetch_sequencer_if #(parameter int CNT_W = 16);
  logic             Start, Halt, BrEq, BrNe, Zero, CfgWe;
  logic [1:0]       BrSel, CfgAddr;
  logic [7:0]       CfgData;
  logic             PcStart, PcJmpEq, PcJmpNe, PcOffsetEn, PcZero, Flush, Busy, Done;
  logic [1:0]       PcRegAddr;
  logic [7:0]       PcOffset;
  logic [CNT_W-1:0] CycleCnt;
  modport slave (
    input  Start, Halt, BrEq, BrNe, Zero, CfgWe, BrSel, CfgAddr, CfgData,
    output PcStart, PcJmpEq, PcJmpNe, PcOffsetEn, PcZero, Flush, Busy, Done, PcRegAddr, PcOffset, CycleCnt
  );
  modport master (
    output Start, Halt, BrEq, BrNe, Zero, CfgWe, BrSel, CfgAddr, CfgData,
    input  PcStart, PcJmpEq, PcJmpNe, PcOffsetEn, PcZero, Flush, Busy, Done, PcRegAddr, PcOffset, CycleCnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: run-control FSM with one-cycle branch issue from a 4-entry offset LUT
module fetch_sequencer #(parameter int CNT_W = 16) (
  input logic Clk,
  input logic Reset,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, BRANCH, DONE} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lut_q [4];
  logic             eq_q, ne_q, zero_q;
  logic [1:0]       sel_q;
  logic [7:0]       off_q;
  logic             take, decide, cfg_wr;
  assign take   = (bus.BrEq & bus.Zero) | (bus.BrNe & ~bus.Zero);
  assign decide = state_q == RUN && !bus.Halt && take;
  assign cfg_wr = bus.CfgWe && (state_q == IDLE || state_q == DONE);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE:    begin state_d = bus.Start ? LOAD : IDLE; cnt_d = bus.Start ? '0 : cnt_q; end
      LOAD:    state_d = RUN;
      RUN:     state_d = bus.Halt ? DONE : take ? BRANCH : RUN;
      BRANCH:  state_d = RUN;
      DONE:    state_d = bus.Start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q == RUN || state_q == BRANCH) && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end
  // branch fields are captured at the decision so they hold steady outside BRANCH
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lut_q <= '{default: '0};
      eq_q <= 1'b0;
      ne_q <= 1'b0;
      zero_q <= 1'b0;
      sel_q <= '0;
      off_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (cfg_wr) lut_q[bus.CfgAddr] <= bus.CfgData;
      if (decide) begin
        eq_q <= bus.BrEq;
        ne_q <= bus.BrNe;
        zero_q <= bus.Zero;
        sel_q <= bus.BrSel;
        off_q <= lut_q[bus.BrSel];
      end
    end
  end
  assign bus.PcStart    = state_q == LOAD;
  assign bus.PcOffsetEn = state_q == BRANCH;
  assign bus.Flush      = state_q == BRANCH;
  assign bus.PcJmpEq    = state_q == BRANCH && eq_q;
  assign bus.PcJmpNe    = state_q == BRANCH && ne_q;
  assign bus.PcZero     = zero_q;
  assign bus.PcRegAddr  = sel_q;
  assign bus.PcOffset   = off_q;
  assign bus.Busy       = state_q == LOAD || state_q == RUN || state_q == BRANCH;
  assign bus.Done       = state_q == DONE;
  assign bus.CycleCnt   = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a scoreboard of expected branch/done events
module tb_fetch_sequencer;
  typedef struct {
    logic       done;
    logic       eq, ne, zero;
    logic [1:0] addr;
    logic [7:0] off;
    int         cnt;
  } item_t;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  item_t sb[$];
  item_t it;
  logic done_q = 1'b0;
  fetch_sequencer_if #(.CNT_W(16)) bus ();
  fetch_sequencer_if #(.CNT_W(4))  bus4 ();
  fetch_sequencer #(.CNT_W(16)) dut  (.Clk(Clk), .Reset(Reset), .bus(bus.slave));
  fetch_sequencer #(.CNT_W(4))  dut4 (.Clk(Clk), .Reset(Reset), .bus(bus4.slave));
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_in();
    bus.Start = 0; bus.Halt = 0; bus.BrEq = 0; bus.BrNe = 0; bus.Zero = 0;
    bus.CfgWe = 0; bus.BrSel = 0; bus.CfgAddr = 0; bus.CfgData = 0;
  endtask

  task automatic push_br(input logic eq, input logic ne, input logic zero, input logic [1:0] addr, input logic [7:0] off);
    sb.push_back('{done: 1'b0, eq: eq, ne: ne, zero: zero, addr: addr, off: off, cnt: 0});
  endtask

  always @(negedge Clk) begin
    if (bus.PcOffsetEn || (bus.Done && !done_q)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got OffsetEn=%0b Done=%0b, expected no event", bus.PcOffsetEn, bus.Done);
      end else begin
        it = sb.pop_front();
        if (it.done) begin
          chk("done_event", 32'(bus.Done), 1);
          chk("done_cnt", 32'(bus.CycleCnt), 32'(it.cnt));
          chk("done_offen", 32'(bus.PcOffsetEn), 0);
        end else begin
          chk("br_offen", 32'(bus.PcOffsetEn), 1);
          chk("br_flush", 32'(bus.Flush), 1);
          chk("br_jmpeq", 32'(bus.PcJmpEq), 32'(it.eq));
          chk("br_jmpne", 32'(bus.PcJmpNe), 32'(it.ne));
          chk("br_zero", 32'(bus.PcZero), 32'(it.zero));
          chk("br_addr", 32'(bus.PcRegAddr), 32'(it.addr));
          chk("br_off", 32'(bus.PcOffset), 32'(it.off));
        end
      end
    end
    done_q = bus.Done;
  end

  initial begin
    clr_in();
    bus4.Start = 0; bus4.Halt = 0; bus4.BrEq = 0; bus4.BrNe = 0; bus4.Zero = 0;
    bus4.CfgWe = 0; bus4.BrSel = 0; bus4.CfgAddr = 0; bus4.CfgData = 0;
    tick();
    tick();
    Reset = 1;
    tick();
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_pcstart", 32'(bus.PcStart), 0);
    chk("rst_offen", 32'(bus.PcOffsetEn), 0);
    chk("rst_flush", 32'(bus.Flush), 0);
    chk("rst_off", 32'(bus.PcOffset), 0);
    chk("rst_addr", 32'(bus.PcRegAddr), 0);
    chk("rst_cnt", 32'(bus.CycleCnt), 0);
    for (int i = 0; i < 4; i++) chk("rst_lut", 32'(dut.lut_q[i]), 0);
    // configure lut[1]=100, lut[2]=25 while idle
    bus.CfgWe = 1; bus.CfgAddr = 1; bus.CfgData = 100;
    tick();
    bus.CfgAddr = 2; bus.CfgData = 25;
    tick();
    bus.CfgWe = 0;
    chk("lut1_wr", 32'(dut.lut_q[1]), 100);
    chk("lut2_wr", 32'(dut.lut_q[2]), 25);
    bus.Start = 1;
    tick();
    chk("load_pcstart", 32'(bus.PcStart), 1);
    chk("load_busy", 32'(bus.Busy), 1);
    chk("load_cnt", 32'(bus.CycleCnt), 0);
    tick();
    bus.Start = 0;
    chk("run_pcstart", 32'(bus.PcStart), 0);
    chk("run_busy", 32'(bus.Busy), 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("run_cnt", 32'(bus.CycleCnt), 32'(k));
    end
    bus.BrEq = 1; bus.Zero = 1; bus.BrSel = 1;
    push_br(1, 0, 1, 1, 100);
    tick();
    // bubble: decoder inputs during BRANCH must not act
    bus.Halt = 1; bus.BrEq = 1; bus.Zero = 1; bus.BrSel = 3;
    tick();
    clr_in();
    chk("post_br_offen", 32'(bus.PcOffsetEn), 0);
    chk("post_br_flush", 32'(bus.Flush), 0);
    chk("post_br_busy", 32'(bus.Busy), 1);
    chk("post_br_done", 32'(bus.Done), 0);
    chk("post_br_hold_off", 32'(bus.PcOffset), 100);
    chk("post_br_hold_addr", 32'(bus.PcRegAddr), 1);
    bus.BrNe = 1; bus.Zero = 1;
    tick();
    chk("brne_z_offen", 32'(bus.PcOffsetEn), 0);
    bus.BrNe = 1; bus.Zero = 0; bus.BrSel = 2;
    push_br(0, 1, 0, 2, 25);
    tick();
    clr_in();
    tick();
    chk("post_brne_jmpne", 32'(bus.PcJmpNe), 0);
    bus.CfgWe = 1; bus.CfgAddr = 1; bus.CfgData = 7;
    tick();
    clr_in();
    chk("run_cfg_blocked", 32'(dut.lut_q[1]), 100);
    bus.BrEq = 1; bus.Zero = 1; bus.BrSel = 3;
    push_br(1, 0, 1, 3, 0);
    tick();
    clr_in();
    tick();
    bus.Halt = 1; bus.BrEq = 1; bus.Zero = 1; bus.Start = 1;
    sb.push_back('{done: 1'b1, eq: 1'b0, ne: 1'b0, zero: 1'b0, addr: 2'd0, off: 8'd0, cnt: 12});
    tick();
    bus.Halt = 0; bus.BrEq = 0; bus.Zero = 0;
    chk("halt_done", 32'(bus.Done), 1);
    chk("halt_busy", 32'(bus.Busy), 0);
    chk("halt_offen", 32'(bus.PcOffsetEn), 0);
    tick();
    tick();
    chk("done_hold", 32'(bus.Done), 1);
    chk("done_cnt_hold", 32'(bus.CycleCnt), 12);
    bus.Start = 0;
    tick();
    chk("idle_done", 32'(bus.Done), 0);
    chk("idle_busy", 32'(bus.Busy), 0);
    chk("idle_cnt_hold", 32'(bus.CycleCnt), 12);
    bus.Start = 1;
    tick();
    chk("restart_cnt_clr", 32'(bus.CycleCnt), 0);
    bus.Start = 0;
    tick();
    bus.BrEq = 1; bus.Zero = 1; bus.BrSel = 1;
    push_br(1, 0, 1, 1, 100);
    tick();
    clr_in();
    Reset = 0;
    tick();
    Reset = 1;
    chk("mid_rst_offen", 32'(bus.PcOffsetEn), 0);
    chk("mid_rst_flush", 32'(bus.Flush), 0);
    chk("mid_rst_jmpeq", 32'(bus.PcJmpEq), 0);
    chk("mid_rst_busy", 32'(bus.Busy), 0);
    chk("mid_rst_done", 32'(bus.Done), 0);
    chk("mid_rst_off", 32'(bus.PcOffset), 0);
    chk("mid_rst_addr", 32'(bus.PcRegAddr), 0);
    chk("mid_rst_zero", 32'(bus.PcZero), 0);
    chk("mid_rst_cnt", 32'(bus.CycleCnt), 0);
    chk("mid_rst_lut1", 32'(dut.lut_q[1]), 0);
    // narrow counter must saturate at 15 over a 21-cycle run
    bus4.Start = 1;
    tick();
    bus4.Start = 0;
    for (int k = 0; k < 20; k++) tick();
    bus4.Halt = 1;
    tick();
    bus4.Halt = 0;
    chk("sat_done", 32'(bus4.Done), 1);
    chk("sat_cnt", 32'(bus4.CycleCnt), 15);
    tick();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the executed-cycle counter.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-low reset, asserted when 0.
REQ-004 The block SHALL have port Start, input, 1 bit: program-run request, level.
REQ-005 The block SHALL have port Halt, input, 1 bit: decoder reports end-of-program instruction.
REQ-006 The block SHALL have ports BrEq and BrNe, input, 1 bit each: decoder reports branch-if-zero and branch-if-not-zero.
REQ-007 The block SHALL have port BrSel, input, 2 bits: branch-target LUT index.
REQ-008 The block SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-009 The block SHALL have ports CfgWe (input, 1 bit), CfgAddr (input, 2 bits) and CfgData (input, 8 bits): offset-LUT write port.
REQ-010 The block SHALL have port PcStart, output, 1 bit: drives the program counter's Start.
REQ-011 The block SHALL have ports PcJmpEq, PcJmpNe and PcOffsetEn, output, 1 bit each: drive the program counter's JmpEq, JmpNe and OffsetEn.
REQ-012 The block SHALL have port PcZero, output, 1 bit: registered copy of Zero for the program counter.
REQ-013 The block SHALL have port PcRegAddr, output, 2 bits: branch target register index.
REQ-014 The block SHALL have port PcOffset, output, 8 bits: branch offset.
REQ-015 The block SHALL have port Flush, output, 1 bit: squash the instruction fetched in the branch cycle.
REQ-016 The block SHALL have ports Busy and Done, output, 1 bit each: status.
REQ-017 The block SHALL have port CycleCnt, output, CNT_W bits: RUN/BRANCH cycles in the current run.

Function
REQ-018 The block SHALL implement states IDLE, LOAD, RUN, BRANCH and DONE.
REQ-019 From IDLE, Start=1 SHALL move to LOAD; otherwise the state SHALL remain IDLE.
REQ-020 LOAD SHALL last exactly one cycle with PcStart=1, then move to RUN.
REQ-021 In RUN, Halt=1 SHALL move to DONE; the branch-taken condition T=(BrEq&Zero)|(BrNe&~Zero) SHALL move to BRANCH; otherwise the state SHALL stay RUN.
REQ-022 Halt and T in the same RUN cycle SHALL resolve to Halt (DONE); no branch outputs are asserted.
REQ-023 BRANCH SHALL last exactly one cycle, then return to RUN.
REQ-024 During BRANCH, PcOffsetEn SHALL be 1, Flush SHALL be 1, PcJmpEq/PcJmpNe SHALL equal the BrEq/BrNe values registered in the decision cycle, PcZero SHALL be the registered Zero, PcRegAddr SHALL be the registered BrSel, and PcOffset SHALL be lut[registered BrSel].
REQ-025 Branch latency SHALL be exactly 1 cycle: the decision is made in RUN cycle N and the outputs are asserted in cycle N+1.
REQ-026 BrEq, BrNe and Halt presented during BRANCH SHALL be ignored (bubble).
REQ-027 Outside BRANCH, PcJmpEq, PcJmpNe, PcOffsetEn and Flush SHALL be 0; PcRegAddr, PcOffset and PcZero SHALL hold their last values.
REQ-028 In DONE, Done SHALL be 1; Start=0 SHALL return the block to IDLE; Start held at 1 SHALL keep it in DONE (no auto-restart).
REQ-029 Busy SHALL be 1 in LOAD, RUN and BRANCH, and 0 otherwise.
REQ-030 CycleCnt SHALL clear on entry to LOAD and increment once per RUN or BRANCH cycle.
REQ-031 CycleCnt SHALL saturate at all-ones with no wrap.
REQ-032 CycleCnt SHALL hold its value in DONE and IDLE.
REQ-033 The LUT SHALL hold 4 entries of 8 bits.
REQ-034 CfgWe=1 SHALL write CfgData to lut[CfgAddr] on the clock edge, only in IDLE or DONE; writes in other states SHALL be ignored.
REQ-035 A LUT write and a branch read of the same entry cannot coincide (writes are blocked while Busy).
REQ-036 Start asserted while Busy SHALL have no effect.

Reset
REQ-037 Reset=0 at a clock edge SHALL force IDLE from any state, including mid-BRANCH.
REQ-038 On reset, all outputs SHALL be 0, CycleCnt SHALL be 0, and all LUT entries SHALL be 0x00.
REQ-039 Reset SHALL take priority over Start, CfgWe and all branch inputs.

Verification
REQ-040 The bench SHALL cover: Reset=0 for 2 cycles, then release -> all outputs 0, state IDLE, lut[0..3]=0.
REQ-041 The bench SHALL cover: LUT write lut[1]=100 in IDLE, Start=1 -> PcStart=1 for one cycle, Busy=1, CycleCnt counting 1,2,3...
REQ-042 The bench SHALL cover: RUN with BrEq=1, Zero=1, BrSel=1 -> next cycle PcOffsetEn=1, PcJmpEq=1, PcRegAddr=01, PcOffset=100, Flush=1 for exactly one cycle.
REQ-043 The bench SHALL cover: BrNe=1, Zero=1 -> no branch; BrNe=1, Zero=0, BrSel=2 with lut[2]=25 -> PcJmpNe=1, PcOffset=25.
REQ-044 The bench SHALL cover: Halt=1 and BrEq=1 with Zero=1 in the same cycle -> DONE, Done=1, PcOffsetEn stays 0; Start dropped -> IDLE.
REQ-045 The bench SHALL cover: CfgWe=1 during RUN -> LUT unchanged; Reset=0 during BRANCH -> next cycle IDLE with all outputs 0; CNT_W=4 run of 20 cycles -> CycleCnt=15.
